// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: default widths,
// the zero-register index and the write-port request bundle.
package wb_arbiter_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] waddr;
      logic [DW_DEF-1:0] wdata;
   } wb_req_t;

   // A write aimed at r0 never reaches the register file.
   function automatic logic is_eff(input wb_req_t r);
      return r.we && (r.waddr != REG_ZERO);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency results; full/empty are decoded
// from a registered occupancy count.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback with buffered/bypassed long-latency results onto
// the single GR write port and tracks registers with pending long-latency writes.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_waddr,
   input  logic [DW-1:0] pipe_wdata,
   input  logic          ll_valid,
   output logic          ll_ready,
   input  logic [AW-1:0] ll_waddr,
   input  logic [DW-1:0] ll_wdata,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   output logic          gr_we,
   output logic [AW-1:0] gr_waddr,
   output logic [DW-1:0] gr_wdata,
   output logic [31:0]   busy,
   output logic          wb_stall
);

   localparam int EW = AW + DW;

   wb_req_t       pipe_req, ll_req, head_req, gr_req;
   logic [EW-1:0] head_raw;
   logic          fifo_full, fifo_empty;
   logic          pipe_eff, head_sel, bypass, push, pop, ll_wr;
   logic [31:0]   busy_d, busy_q;

   assign pipe_req = '{we: pipe_we, waddr: pipe_waddr, wdata: pipe_wdata};
   assign ll_req   = '{we: ll_valid, waddr: ll_waddr, wdata: ll_wdata};
   assign head_req = '{we: !fifo_empty, waddr: head_raw[EW-1:DW], wdata: head_raw[DW-1:0]};

   assign pipe_eff = is_eff(pipe_req);
   assign head_sel = rst_n && !pipe_eff && !fifo_empty;
   assign bypass   = rst_n && !pipe_eff && fifo_empty && ll_valid;
   assign ll_ready = rst_n && !fifo_full;
   assign push     = ll_valid && ll_ready && !bypass;
   assign pop      = head_sel;

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({ll_waddr, ll_wdata}),
      .rdata_o (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Priority: pipeline, then FIFO head, then same-cycle bypass. A consumed
   // result addressed to r0 leaves the port idle.
   always_comb begin
      gr_req = '0;
      if (!rst_n)        gr_req = '0;
      else if (pipe_eff) gr_req = pipe_req;
      else if (head_sel) gr_req = head_req;
      else if (bypass)   gr_req = ll_req;
      if (!is_eff(gr_req)) gr_req = '0;
   end

   assign ll_wr = gr_req.we && !pipe_eff;

   // Set is applied after clear so a same-cycle reissue keeps the bit high.
   always_comb begin
      busy_d = busy_q;
      if (ll_wr) busy_d[gr_req.waddr] = 1'b0;
      if (issue_valid && (issue_rd != REG_ZERO)) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign gr_we    = gr_req.we;
   assign gr_waddr = gr_req.waddr;
   assign gr_wdata = gr_req.wdata;
   assign busy     = busy_q;
   assign wb_stall = rst_n && fifo_full;

endmodule
